// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer driving the PC strobes, fetching from memory and issuing to execute.
// Latency: 3 cycles/instruction, 2 per jump, +1 per Mem_Ready or Instr_Ack wait cycle.
// Backpressure: Mem_Req held until Mem_Ready, Instr_Valid until Instr_Ack; FETCH_WRAP_TRAP_EN traps PC wrap.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module fetch_ctrl #(
  parameter int                      INSTR_WIDTH  = 16,
  parameter int                      OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] JMP_OPCODE   = 4'hE,
  parameter logic [OPCODE_WIDTH-1:0] HLT_OPCODE   = 4'hF
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   Halt,
  input  logic [`ADDR_WIDTH-1:0] PC_Out,
  output logic                   PC_Clr,
  output logic                   PC_Load,
  output logic                   PC_Inc,
  output logic [`ADDR_WIDTH-1:0] Dest_Reg,
  output logic                   Mem_Req,
  output logic [`ADDR_WIDTH-1:0] Mem_Addr,
  input  logic                   Mem_Ready,
  input  logic [INSTR_WIDTH-1:0] Mem_Data,
  output logic                   Instr_Valid,
  output logic [INSTR_WIDTH-1:0] Instr_Out,
  input  logic                   Instr_Ack,
  input  logic                   Jump_Req,
  input  logic [`ADDR_WIDTH-1:0] Jump_Addr,
  output logic                   Halted,
  output logic                   Fault
);

  if (`ADDR_WIDTH > INSTR_WIDTH - OPCODE_WIDTH) begin : g_width_chk
    $error("fetch_ctrl: jump target field overlaps the opcode");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DECODE, ISSUE, HALTED} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [INSTR_WIDTH-1:0]  instr_reg;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    start_go;

  assign opcode   = instr_reg[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign start_go = Start && (state == IDLE || state == HALTED);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      instr_reg <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && Mem_Ready) instr_reg <= Mem_Data;
    end
  end

`ifdef FETCH_WRAP_TRAP_EN
  logic wrap_trap;
  logic fault_q;

  // Sticky until the next reset or accepted Start.
  always_ff @(posedge Clk) begin
    if (Rst)            fault_q <= 1'b0;
    else if (start_go)  fault_q <= 1'b0;
    else if (wrap_trap) fault_q <= 1'b1;
  end

  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    PC_Clr      = 1'b0;
    PC_Load     = 1'b0;
    PC_Inc      = 1'b0;
    Dest_Reg    = '0;
    Mem_Req     = 1'b0;
    Mem_Addr    = '0;
    Instr_Valid = 1'b0;
    Instr_Out   = '0;
    Halted      = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
    wrap_trap   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_go) state_nxt = CLEAR;
      end
      CLEAR: begin
        PC_Clr    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        Mem_Req  = 1'b1;
        Mem_Addr = PC_Out;
        if (Mem_Ready) state_nxt = DECODE;
      end
      DECODE: begin
        if (opcode == JMP_OPCODE) begin
          PC_Load   = 1'b1;
          Dest_Reg  = instr_reg[`ADDR_WIDTH-1:0];
          state_nxt = Halt ? HALTED : FETCH;
        end else if (opcode == HLT_OPCODE) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        Instr_Valid = 1'b1;
        Instr_Out   = instr_reg;
        if (Instr_Ack) begin
          state_nxt = Halt ? HALTED : FETCH;
          if (Jump_Req) begin
            PC_Load  = 1'b1;
            Dest_Reg = Jump_Addr;
          end
`ifdef FETCH_WRAP_TRAP_EN
          else if (&PC_Out) begin
            wrap_trap = 1'b1;
            state_nxt = HALTED;
          end
`endif
          else begin
            PC_Inc = 1'b1;
          end
        end
      end
      HALTED: begin
        Halted = 1'b1;
        if (start_go) state_nxt = CLEAR;
      end
      default: state_nxt = IDLE;
    endcase
    // An aborting reset must never move the PC.
    if (Rst) begin
      PC_Clr   = 1'b0;
      PC_Load  = 1'b0;
      PC_Inc   = 1'b0;
      Dest_Reg = '0;
    end
  end

endmodule
